// File: rtl/matrix_scan_controller.sv
// Column-multiplexed LED matrix scanner: per column FETCH row data, SHOW for dwell cycles,
// BLANK for blank cycles, then advance the column pointer in the selected direction.
module matrix_scan_controller #(
   parameter int unsigned COLS    = 5,
   parameter int unsigned ROWS    = 7,
   parameter int unsigned DWELL_W = 16,
   parameter int unsigned BLANK_W = 4,
   parameter int unsigned AW      = $clog2(COLS)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_enable,
   input  logic               i_restart,
   input  logic               i_dir,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic [BLANK_W-1:0] i_blank,
   input  logic [ROWS-1:0]    i_row_data,
   output logic [AW-1:0]      o_col_addr,
   output logic [COLS-1:0]    o_col_drive,
   output logic [ROWS-1:0]    o_row_drive,
   output logic               o_frame_start,
   output logic               o_busy
);

   localparam int unsigned CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

   typedef enum logic [1:0] {IDLE, FETCH, SHOW, BLANK} state_t;

   state_t              r_state, w_state_nxt;
   logic [AW-1:0]       r_ptr, w_ptr_nxt, w_ptr_adv;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [DWELL_W-1:0]  r_dwell, w_dwell_nxt;
   logic [BLANK_W-1:0]  r_blank, w_blank_nxt;
   logic [COLS-1:0]     r_col_drive, w_col_drive_nxt;
   logic [ROWS-1:0]     r_row_drive, w_row_drive_nxt;
   logic                r_frame_start, w_frame_start_nxt;
   logic                r_busy, w_busy_nxt;

   // Pointer step with wrap in either direction; dir only matters on the advance edge
   assign w_ptr_adv = i_dir ? ((r_ptr == '0) ? AW'(COLS - 1) : r_ptr - AW'(1))
                            : ((r_ptr == AW'(COLS - 1)) ? '0 : r_ptr + AW'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_ptr         <= '0;
         r_cnt         <= '0;
         r_dwell       <= '0;
         r_blank       <= '0;
         r_col_drive   <= '0;
         r_row_drive   <= '0;
         r_frame_start <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_cnt         <= w_cnt_nxt;
         r_dwell       <= w_dwell_nxt;
         r_blank       <= w_blank_nxt;
         r_col_drive   <= w_col_drive_nxt;
         r_row_drive   <= w_row_drive_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_busy        <= w_busy_nxt;
      end
   end

   // Next state: restart beats enable, enable beats the normal scan sequence
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_dwell_nxt = r_dwell;
      w_blank_nxt = r_blank;
      if (i_restart) begin
         w_ptr_nxt   = '0;
         w_state_nxt = i_enable ? FETCH : IDLE;
      end else if (!i_enable) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: w_state_nxt = FETCH;
            FETCH: begin
               w_dwell_nxt = i_dwell;
               w_blank_nxt = i_blank;
               w_cnt_nxt   = (i_dwell == '0) ? '0 : CNT_W'(i_dwell - DWELL_W'(1));
               w_state_nxt = SHOW;
            end
            SHOW: begin
               if (r_cnt == '0) begin
                  w_ptr_nxt = w_ptr_adv;
                  if (r_blank != '0) begin
                     w_cnt_nxt   = CNT_W'(r_blank - BLANK_W'(1));
                     w_state_nxt = BLANK;
                  end else begin
                     w_state_nxt = FETCH;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            BLANK: begin
               if (r_cnt == '0) w_state_nxt = FETCH;
               else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Registered outputs follow the next state; drives are only non-zero while in SHOW
   always_comb begin
      w_col_drive_nxt   = '0;
      w_row_drive_nxt   = '0;
      w_frame_start_nxt = (w_state_nxt == FETCH) && (w_ptr_nxt == '0);
      w_busy_nxt        = (w_state_nxt != IDLE);
      if (w_state_nxt == SHOW) begin
         if (r_state == FETCH) begin
            w_col_drive_nxt = COLS'(1) << r_ptr;
            w_row_drive_nxt = i_row_data;
         end else begin
            w_col_drive_nxt = r_col_drive;
            w_row_drive_nxt = r_row_drive;
         end
      end
   end

   assign o_col_addr    = r_ptr;
   assign o_col_drive   = r_col_drive;
   assign o_row_drive   = r_row_drive;
   assign o_frame_start = r_frame_start;
   assign o_busy        = r_busy;

endmodule

// File: doc/matrix_scan_controller.md
MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 Parameter COLS, default 5: number of matrix columns; legal range 2..32.
REQ-002 Parameter ROWS, default 7: number of matrix rows; legal range 1..32.
REQ-003 Parameter DWELL_W, default 16: width of the dwell input.
REQ-004 Parameter BLANK_W, default 4: width of the blank input.
REQ-005 Parameter AW, default $clog2(COLS): width of col_addr.
REQ-006 clock  input  1  system clock; all state updates occur on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  scanning enabled when high.
REQ-009 restart  input  1  synchronous request to return the column pointer to 0.
REQ-010 dir  input  1  scan direction: 0 = ascending, 1 = descending.
REQ-011 dwell  input  DWELL_W  column on-time in clock cycles.
REQ-012 blank  input  BLANK_W  inter-column blanking in clock cycles.
REQ-013 row_data  input  ROWS  row pattern for the column at col_addr; sampled at the end of the FETCH cycle.
REQ-014 col_addr  output  AW  current column pointer.
REQ-015 col_drive  output  COLS  one-hot active column; all zeros when no column is lit.
REQ-016 row_drive  output  ROWS  registered row pattern of the lit column.
REQ-017 frame_start  output  1  one-cycle pulse at the start of a new frame.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, FETCH, SHOW and BLANK.
REQ-020 IDLE: col_drive=0 and row_drive=0; if enable=1, next state is FETCH, otherwise remain in IDLE.
REQ-021 FETCH lasts one cycle; it latches dwell and blank into internal registers and, on exit, loads row_drive from row_data and col_drive with the one-hot of the pointer, then enters SHOW.
REQ-022 SHOW lasts max(latched dwell, 1) cycles, with col_drive and row_drive held constant.
REQ-023 On SHOW exit, the pointer advances, col_drive=0 and row_drive=0; the next state is BLANK if latched blank>0, otherwise FETCH.
REQ-024 BLANK lasts exactly latched-blank cycles, with col_drive and row_drive at zero, then enters FETCH.
REQ-025 Advance with dir=0: the pointer increments, and COLS-1 wraps to 0.
REQ-026 Advance with dir=1: the pointer decrements, and 0 wraps to COLS-1.
REQ-027 dir SHALL be sampled only at the advance edge.
REQ-028 col_addr SHALL equal the pointer at all times; the pointer never exceeds COLS-1.
REQ-029 frame_start SHALL be high during every FETCH cycle in which the pointer is 0, and low at all other times.
REQ-030 enable=0 in any non-IDLE state: next state is IDLE, col_drive and row_drive clear on that edge, and the pointer is retained.
REQ-031 Re-enabling after enable=0 SHALL resume at FETCH of the retained pointer.
REQ-032 restart=1 SHALL set the pointer to 0 on the next edge and force the FSM to FETCH if enable=1, or to IDLE if enable=0; col_drive and row_drive clear on that edge.
REQ-033 restart SHALL take priority over advance and over enable-driven transitions.
REQ-034 Changes to dwell or blank outside FETCH SHALL have no effect until the next FETCH.
REQ-035 col_drive SHALL never have more than one bit set in any cycle.

Reset
REQ-036 While reset is high: state=IDLE, pointer=0, col_drive=0, row_drive=0, frame_start=0, busy=0, and latched dwell and blank are 0.
REQ-037 Reset asserted mid-SHOW SHALL blank the outputs immediately, without waiting for a clock edge.

Verification
REQ-038 Scenario: COLS=5, dwell=3, blank=2, dir=0, enable=1 after reset -> col_drive cycles 00001, 00010, 00100, 01000, 10000, 00001; each column on 3 cycles, followed by 2 zero cycles; column period 6 cycles; frame_start every 30 cycles.
REQ-039 Scenario: dir=1, starting at pointer 0 -> col_addr sequence 0, 4, 3, 2, 1, 0.
REQ-040 Scenario: dwell=0, blank=0 -> each column on for 1 cycle, back-to-back with FETCH; col_drive=0 during each FETCH; 2-cycle column period.
REQ-041 Scenario: enable dropped during SHOW of column 2, then re-asserted -> outputs go to 0 on the next edge, busy=0; resumes with FETCH of column 2, col_addr=2.
REQ-042 Scenario: restart pulsed in SHOW of column 3, same cycle as the dwell expiry -> pointer=0, next state FETCH, frame_start pulses.
REQ-043 Scenario: row_data=7'h55 for column 1, dwell changed from 3 to 8 mid-SHOW -> row_drive=7'h55 while col_drive=00010; current column stays 3 cycles, and the next column lasts 8 cycles.
